// File: rtl/sauria_cfg_sequencer.sv
// sauria_seq_fifo: generic synchronous FIFO with flush, pointer wrap modulo DEPTH (DEPTH power of two).
// Latency: write visible at read port the cycle after the push; read data is the combinational head.
// Backpressure: full_o/empty_o gate push/pop internally; flush_i empties it and overrides push/pop.
module sauria_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem[rd_ptr_q];

    // Storage array: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; push+pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end
endmodule

// sauria_cfg_sequencer: queues config writes, replays them to the SAURIA config bridge, launches the job, waits for done.
// Latency: push into an idle empty queue raises cfg_req_o after the second edge; irq_o one cycle after the done edge.
// Backpressure: cmd_ready_o low when queue full, in ERR or in reset; each config write is held until cfg_gnt_i.
// Optional: define SAURIA_SEQ_WDOG_EN to build a WAIT_DONE watchdog that errors after TIMEOUT_CYCLES.
module sauria_cfg_sequencer #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR     = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [DATA_WIDTH-1:0] START_DATA     = DATA_WIDTH'(32'h0000_0001),
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    input  logic                  cmd_last_i,
    output logic                  cfg_req_o,
    input  logic                  cfg_gnt_i,
    output logic [ADDR_WIDTH-1:0] cfg_addr_o,
    output logic [DATA_WIDTH-1:0] cfg_wdata_o,
    input  logic                  cfg_error_i,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  irq_o,
    output logic                  err_o,
    input  logic                  clr_err_i
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        START,
        WAIT_DONE,
        ERR
    } state_t;

    state_t state_q;
    state_t state_d;
    cmd_t   push_cmd;
    cmd_t   head_cmd;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_flush;
    logic   ready_en_q;
    logic   done_q;
    logic   done_rise;
    logic   irq_q;
    logic   irq_set;
    logic   wdog_expired;

    assign push_cmd    = '{addr: cmd_addr_i, data: cmd_data_i, last: cmd_last_i};
    assign cmd_ready_o = ready_en_q && !fifo_full && (state_q != ERR);
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign done_rise   = done_i && !done_q;
    assign busy_o      = (state_q == ISSUE) || (state_q == START) || (state_q == WAIT_DONE);
    assign err_o       = (state_q == ERR);
    assign irq_o       = irq_q;

    sauria_seq_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (push_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef SAURIA_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt_q;

    // Watchdog counts cycles spent in WAIT_DONE, held at zero everywhere else.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
        end else if (state_q != WAIT_DONE) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
        end
    end

    assign wdog_expired = (state_q == WAIT_DONE) && (wdog_cnt_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign wdog_expired = 1'b0;
`endif

    // State, done history (reset high so a level held through reset is not an edge), irq pulse, ready enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            irq_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_i;
            irq_q      <= irq_set;
            ready_en_q <= 1'b1;
        end
    end

    // Next state and config-bus outputs; the bus reads zero whenever no write is offered.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        irq_set     = 1'b0;
        cfg_req_o   = 1'b0;
        cfg_addr_o  = '0;
        cfg_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cfg_req_o = !fifo_empty;
                if (!fifo_empty) begin
                    cfg_addr_o  = head_cmd.addr;
                    cfg_wdata_o = head_cmd.data;
                    if (cfg_gnt_i) begin
                        fifo_pop = 1'b1;
                        if (cfg_error_i) begin
                            state_d = ERR;
                        end else if (head_cmd.last) begin
                            state_d = START;
                        end
                    end
                end
            end
            START: begin
                cfg_req_o   = 1'b1;
                cfg_addr_o  = START_ADDR;
                cfg_wdata_o = START_DATA;
                if (cfg_gnt_i) begin
                    state_d = cfg_error_i ? ERR : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    irq_set = 1'b1;
                    state_d = IDLE;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                fifo_flush = 1'b1;
                if (clr_err_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: doc/sauria_cfg_sequencer.md
SAURIA_CFG_SEQUENCER -- requirements
Module: sauria_cfg_sequencer

Interface
REQ-001: Parameter ADDR_WIDTH, default 32, SHALL set the width of configuration write addresses.
REQ-002: Parameter DATA_WIDTH, default 32, SHALL set the width of configuration write data.
REQ-003: Parameter FIFO_DEPTH, default 8 (power of two, >=2), SHALL set the number of queued command entries.
REQ-004: Parameter START_ADDR, default 32'h0000_0000, SHALL be the SAURIA control register address written to launch a job.
REQ-005: Parameter START_DATA, default 32'h0000_0001, SHALL be the value written to START_ADDR.
REQ-006: Parameter TIMEOUT_CYCLES, default 1_000_000, SHALL set the watchdog limit when the watchdog is compiled in.
REQ-007: Port clk_i, input, 1: the single clock; all state SHALL be rising-edge clocked.
REQ-008: Port rst_ni, input, 1: asynchronous active-low reset.
REQ-009: Ports cmd_valid_i in 1 / cmd_ready_o out 1: command push handshake.
REQ-010: Ports cmd_addr_i in ADDR_WIDTH / cmd_data_i in DATA_WIDTH: config write address and data.
REQ-011: Port cmd_last_i, input, 1: marks the final config write of a job.
REQ-012: Ports cfg_req_o out 1 / cfg_gnt_i in 1: config write request and grant toward the SAURIA config bridge.
REQ-013: Ports cfg_addr_o out ADDR_WIDTH / cfg_wdata_o out DATA_WIDTH: config write address and data.
REQ-014: Port cfg_error_i, input, 1: write error, sampled only in the grant cycle.
REQ-015: Port done_i, input, 1: SAURIA done interrupt (level).
REQ-016: Ports busy_o out 1 / irq_o out 1 / err_o out 1: job in flight, one-cycle job-complete pulse, sticky error.
REQ-017: Port clr_err_i, input, 1: clears the error state.

Function
REQ-018: Command FIFO SHALL store {addr, data, last}; cmd_ready_o = !full && state != ERR; a push occurs on cmd_valid_i && cmd_ready_o.
REQ-019: Simultaneous push and pop SHALL leave the occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-020: FSM states SHALL be IDLE, ISSUE, START, WAIT_DONE and ERR.
REQ-021: IDLE -> ISSUE when the FIFO is non-empty; a push into an empty FIFO in IDLE at edge N SHALL give cfg_req_o=1 in cycle N+2.
REQ-022: In ISSUE, cfg_req_o SHALL equal FIFO non-empty, with cfg_addr_o/cfg_wdata_o taken from the FIFO head and held stable until cfg_gnt_i.
REQ-023: On ISSUE grant: pop; if cfg_error_i -> ERR; else if head.last -> START; else stay in ISSUE.
REQ-024: START SHALL drive cfg_req_o=1 with START_ADDR/START_DATA; on grant go to ERR if cfg_error_i, else WAIT_DONE.
REQ-025: done_i SHALL be registered once; in WAIT_DONE a rising edge (done_i=1, registered value 0) SHALL pulse irq_o for exactly one cycle and return to IDLE.
REQ-026: done_i edges in any state other than WAIT_DONE SHALL be ignored; a level already high on entry to WAIT_DONE SHALL NOT complete the job.
REQ-027: busy_o SHALL be 1 in ISSUE, START and WAIT_DONE, and 0 in IDLE and ERR.
REQ-028: ERR SHALL hold err_o=1 and flush the FIFO each cycle; clr_err_i -> IDLE with err_o=0 the next cycle.
REQ-029: cfg_req_o SHALL be 0 in IDLE, WAIT_DONE and ERR.

Reset
REQ-030: While rst_ni=0: state=IDLE, FIFO empty, cfg_req_o=0, cfg_addr_o=0, cfg_wdata_o=0, busy_o=0, irq_o=0, err_o=0, cmd_ready_o=0, watchdog=0; the registered done_i SHALL reset to 1.
REQ-031: Reset mid-job SHALL abandon the in-flight write and discard all queued commands; no irq_o SHALL follow.

Configuration
REQ-032: Macro SAURIA_SEQ_WDOG_EN defined: a counter SHALL clear on entry to WAIT_DONE and increment each cycle in WAIT_DONE; reaching TIMEOUT_CYCLES without a done edge -> ERR.
REQ-033: Macro SAURIA_SEQ_WDOG_EN undefined: no counter is built, WAIT_DONE SHALL wait indefinitely, and TIMEOUT_CYCLES is ignored.

Verification
REQ-034: Push 3 cmds (0x10/0xA, 0x14/0xB, 0x18/0xC last), gnt always 1 -> 3 writes in order, then write 0x0/0x1, busy_o=1; done_i rises -> irq_o single pulse, IDLE.
REQ-035: cfg_gnt_i held 0 for 5 cycles during ISSUE -> cfg_req_o, cfg_addr_o and cfg_wdata_o stable all 5 cycles; pop only on grant.
REQ-036: Push 8 cmds with no last and gnt=0 -> cmd_ready_o=0 after the 8th push; one grant -> cmd_ready_o=1 the next cycle.
REQ-037: cfg_error_i=1 on the 2nd grant -> err_o=1, FIFO flushed, cmd_ready_o=0; clr_err_i pulse -> IDLE, err_o=0.
REQ-038: done_i high before START completes -> no irq_o; done_i low then high -> irq_o pulse.
REQ-039: With SAURIA_SEQ_WDOG_EN and TIMEOUT_CYCLES=16, done_i never rises -> ERR after 16 WAIT_DONE cycles; without the macro the block stays in WAIT_DONE.
